// File: rtl/md_unit_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// operator encodings, default latencies, FSM state encoding and op-class helpers.
package md_defs;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // Ops 0-3 are the multi-cycle arithmetic ops; bit 1 separates divide from multiply.
  function automatic logic is_long_op(input logic [2:0] op);
    return ~op[2];
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Request/response bundle between the E stage and the multiply/divide unit.
// The pipeline side drives the request; the unit returns busy and HI/LO.
interface md_unit_if;
  import md_defs::*;

  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_val, rt_val,
    input  md_busy, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val,
    output md_busy, hi, lo
  );

endinterface

// File: rtl/md_unit_compute.sv
// Combinational 64-bit MULT/MULTU/DIV/DIVU result ({hi,lo}) plus divide-by-zero flag.
// The result is captured by the top on the start edge; latency is modelled there.
module md_compute
  import md_defs::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0]        rs_sx;
  logic [63:0]        rt_sx;
  logic signed [31:0] s_rs;
  logic signed [31:0] s_rt;
  logic signed [31:0] s_quo;
  logic signed [31:0] s_rem;

  assign rs_sx = {{32{rs[31]}}, rs};
  assign rt_sx = {{32{rt[31]}}, rt};
  assign s_rs  = $signed(rs);
  assign s_rt  = $signed(rt);

  // NOTE: every output and temporary gets a default before the case so no latch is inferred.
  always_comb begin
    result   = '0;
    div_zero = 1'b0;
    s_quo    = '0;
    s_rem    = '0;
    case (op)
      MD_MULT:  result = rs_sx * rt_sx;
      MD_MULTU: result = {32'd0, rs} * {32'd0, rt};
      MD_DIV: begin
        if (rt == 32'd0) begin
          div_zero = 1'b1;
        end else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
          // The only overflowing quotient; pin it rather than trust the divider.
          result = {32'd0, 32'h8000_0000};
        end else begin
          s_quo  = s_rs / s_rt;
          s_rem  = s_rs % s_rt;
          result = {s_rem, s_quo};
        end
      end
      MD_DIVU: begin
        if (rt == 32'd0) begin
          div_zero = 1'b1;
        end else begin
          result = {rs % rt, rs / rt};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit: owns HI/LO, runs long ops as a counted busy window and
// commits the latched result on the last busy edge; MTHI/MTLO write immediately.
module md_unit
  import md_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  md
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int          CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        pend_hi_q, pend_hi_d;
  logic [31:0]        pend_lo_q, pend_lo_d;
  logic               pend_dz_q, pend_dz_d;

  logic [63:0]        result;
  logic               div_zero;

  md_compute u_compute (
    .op       (md.md_op),
    .rs       (md.rs_val),
    .rt       (md.rt_val),
    .result   (result),
    .div_zero (div_zero)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    case (state_q)
      ST_IDLE: begin
        if (md.start) begin
          if (is_long_op(md.md_op)) begin
            pend_hi_d = result[63:32];
            pend_lo_d = result[31:0];
            pend_dz_d = div_zero;
            cnt_d     = is_div_op(md.md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_d   = ST_BUSY;
          end else if (md.md_op == MD_MTHI) begin
            hi_d = md.rs_val;
          end else if (md.md_op == MD_MTLO) begin
            lo_d = md.rs_val;
          end
        end
      end
      ST_BUSY: begin
        // Any start seen here is dropped; the hazard unit keeps D stalled meanwhile.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (!pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
    end
  end

  // The start term covers the issue cycle so the hazard unit stalls from the first cycle.
  assign md.md_busy = (md.start & is_long_op(md.md_op)) | (state_q == ST_BUSY);
  assign md.hi      = hi_q;
  assign md.lo      = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Execute-stage multiply/divide unit. Consumes the decoded operator and the forwarded RS/RT operand values that the D→E pipeline register presents to the E stage.
- Owns the HI/LO architectural registers.
- Runs MULT/MULTU/DIV/DIVU as multi-cycle operations and raises md_busy. The hazard unit uses md_busy to hold D and insert a bubble into the E register.
- Also services MTHI/MTLO writes and supplies HI/LO for MFHI/MFLO.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU after the start cycle (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU after the start cycle (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  E-stage instruction is an md op; qualifies md_op
- md_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (treated as no-op)
- rs_val  in  32  forwarded RS operand in E
- rt_val  in  32  forwarded RT operand in E
- md_busy  out  1  start(for ops 0-3) OR internal busy; combinational OR of registered busy
- hi  out  32  HI register value
- lo  out  32  LO register value

Behaviour:
- Reset (reset==0, async): state=IDLE, cnt=0, hi=0, lo=0, result latches=0; md_busy is then driven only by the start term.
- States:
  - IDLE: accepts start.
  - BUSY: counts down; ignores start.
- IDLE, start, md_op 0-3 at edge:
  - Latch the 64-bit result computed from rs_val/rt_val into pend_hi/pend_lo.
  - Load cnt = MULT_CYCLES (ops 0-1) or DIV_CYCLES (ops 2-3); go to BUSY.
  - hi/lo keep their old values.
- BUSY: each edge cnt decrements. On the edge where cnt==1: hi<=pend_hi, lo<=pend_lo, state<=IDLE.
- md_busy timing:
  - High in the start cycle via the combinational term.
  - Then high for exactly N further cycles.
  - hi/lo carry new values in the first cycle md_busy is low.
- MULT: {hi,lo} = signed(rs)*signed(rt), full 64-bit. MULTU: unsigned 64-bit.
- DIV/DIVU: lo=quotient, hi=remainder.
  - Signed division truncates toward zero; remainder takes the dividend's sign.
  - -2^31 / -1: lo=0x80000000, hi=0.
- Divide by zero (rt_val==0, op 2/3): runs full DIV_CYCLES busy; hi/lo left unchanged at completion.
- MTHI/MTLO in IDLE: hi (or lo) <= rs_val at the start edge; no busy cycles; md_busy not asserted for ops 4-5.
- start while BUSY (any op): ignored, no state change. The hazard unit guarantees this does not occur; it is checked by assertion only.
- Reserved md_op with start: no effect.
- reset asserted mid-BUSY: abort immediately; pending result discarded; hi/lo=0.
- md_busy is never X: busy flag is registered, start is ANDed with op decode.

Decomposition:
- Shared package `md_defs`:
  - md_op encodings (MD_MULT..MD_MTLO)
  - default cycle counts
  - state encoding (IDLE/BUSY)
- One natural sub-module, `md_compute`: combinational 64-bit result and divide-by-zero flag from op/rs/rt. The top holds the FSM, counter and HI/LO registers.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=3, start 1 cycle:
  - md_busy high for 6 cycles total.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - hi/lo unchanged during busy.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=-7 (0xFFFFFFF9), rt=2:
  - md_busy 11 cycles.
  - Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=7, rt=0 after MTHI 0x1234 and MTLO 0x5678:
  - MT writes visible the next cycle with no busy.
  - Divide runs 10 busy cycles; hi=0x1234, lo=0x5678 unchanged.
- DIV rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0. Then issue start(MULT) while BUSY: ignored, count unaffected.
- Start MULT, assert reset low at busy cycle 3:
  - md_busy, hi, lo drop to 0 asynchronously.
  - After release: IDLE, next MTLO 0xA5A5A5A5 lands.
